// File: rtl/bootrom_arbiter.sv
// Round-robin arbiter sharing one single-outstanding boot ROM port between NUM_REQ requesters.
// A watchdog turns a missing ROM response into an error response so no requester hangs.
module bootrom_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 24,
  parameter int DATA_WIDTH     = 128,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [NUM_REQ-1:0]            resp_valid_o,
  output logic [DATA_WIDTH-1:0]         resp_data_o,
  output logic                          resp_err_o,
  output logic [ADDR_WIDTH-1:0]         brom_req_address_o,
  output logic                          brom_req_valid_o,
  input  logic                          brom_ready_i,
  input  logic [DATA_WIDTH-1:0]         brom_resp_data_i,
  input  logic                          brom_resp_valid_i
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  // Fires on the last WAIT cycle, so the error response lands TIMEOUT_CYCLES after the strobe.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]            state;
  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         owner;
  logic [CW-1:0]         cnt;
  logic [PW-1:0]         grant;
  logic [PW-1:0]         next_ptr;
  logic [PW:0]           cand;
  logic                  any_req;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] sel_addr;

  always_comb begin
    grant   = rr_ptr;
    any_req = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(NUM_REQ)) cand = cand - (PW+1)'(NUM_REQ);
      if (!any_req && req_valid_i[cand[PW-1:0]]) begin
        grant   = cand[PW-1:0];
        any_req = 1'b1;
      end
    end
  end

  assign next_ptr = (grant == PW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
  assign sel_addr = req_addr_i[grant*ADDR_WIDTH +: ADDR_WIDTH];
  assign accept   = !rst && (state == S_IDLE) && any_req;

  always_comb begin
    req_ready_o = '0;
    if (accept) req_ready_o[grant] = 1'b1;
  end

  // The ROM latches its address on any strobe, so never raise it while the ROM is busy.
  assign brom_req_valid_o = !rst && (state == S_ISSUE) && brom_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_IDLE;
      rr_ptr             <= '0;
      owner              <= '0;
      cnt                <= '0;
      resp_valid_o       <= '0;
      resp_err_o         <= 1'b0;
      resp_data_o        <= '0;
      brom_req_address_o <= '0;
    end else begin
      resp_valid_o <= '0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            owner              <= grant;
            brom_req_address_o <= {sel_addr[ADDR_WIDTH-1:4], 4'b0000};
            rr_ptr             <= next_ptr;
            state              <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (brom_ready_i) begin
            cnt   <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          // A real response beats a coincident timeout.
          if (brom_resp_valid_i) begin
            resp_valid_o[owner] <= 1'b1;
            resp_data_o         <= brom_resp_data_i;
            resp_err_o          <= 1'b0;
            state               <= S_IDLE;
          end else if (cnt == CNT_LAST) begin
            resp_valid_o[owner] <= 1'b1;
            resp_data_o         <= '0;
            resp_err_o          <= 1'b1;
            state               <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
